truth_table_scanner: RTL

- Sequential counterpart to the lab's 4-input combinational function blocks: drives all 16 input vectors onto a function under test (FUT) and reads its single output back.
- Assembles the measured 16-bit truth table and compares it against an expected table.
- Sits between the board's start button logic and any 4-in/1-out combinational block; used for on-board self-check of combinational lab designs.

---
 rtl/truth_table_scanner_pkg.sv | 16 +
 rtl/truth_table_scanner_popcount16.sv | 19 +
 rtl/truth_table_scanner.sv | 114 +++++++++++
 3 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and widths for the truth table scanner.
// Imported by the scanner top and its popcount helper.
package truth_table_scanner_pkg;

   localparam int VEC_W   = 4;
   localparam int TABLE_W = 16;
   localparam int CNT_W   = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } state_t;

endpackage

// File: rtl/truth_table_scanner_popcount16.sv
// Counts differing bits between two 16-bit tables.
// Five-bit result so a full inversion (16) fits.
module truth_table_scanner_popcount16
   import truth_table_scanner_pkg::*;
(
   input  logic [TABLE_W-1:0] a,
   input  logic [TABLE_W-1:0] b,
   output logic [CNT_W-1:0]   cnt
);

   // sum of the XOR bits
   always_comb begin
      cnt = '0;
      for (int i = 0; i < TABLE_W; i++) begin
         cnt = cnt + CNT_W'(a[i] ^ b[i]);
      end
   end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks a 4-in/1-out function through all 16 vectors,
// records its truth table and compares it to EXPECTED.
module truth_table_scanner
   import truth_table_scanner_pkg::*;
#(
   parameter int                 SETTLE_CYCLES = 1,
   parameter logic [TABLE_W-1:0] EXPECTED      = 16'hADA7
) (
   input  logic               iClk,
   input  logic               iRst_n,
   input  logic               iStart,
   input  logic               iY,
   output logic               oA,
   output logic               oB,
   output logic               oC,
   output logic               oD,
   output logic               oBusy,
   output logic               oDone,
   output logic [TABLE_W-1:0] oTable,
   output logic               oMatch,
   output logic [CNT_W-1:0]   oErrCnt
);

   state_t             state;
   logic [VEC_W-1:0]   vec;
   logic [3:0]         settle;
   logic [CNT_W-1:0]   acc;
   logic [VEC_W-1:0]   drv;
   logic [TABLE_W-1:0] tbl_next;
   logic [CNT_W-1:0]   acc_next;
   logic [CNT_W-1:0]   pop;
   logic               miss;

   assign {oA, oB, oC, oD} = drv;

   assign miss     = iY ^ EXPECTED[vec];
   assign acc_next = acc + CNT_W'(miss);

   // table as it will look after the current sample lands
   always_comb begin
      tbl_next      = oTable;
      tbl_next[vec] = iY;
   end

   truth_table_scanner_popcount16 u_pop (
      .a   (tbl_next),
      .b   (EXPECTED),
      .cnt (pop)
   );

   // scan FSM with vector/settle counters and registered outputs
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state   <= IDLE;
         vec     <= '0;
         settle  <= '0;
         acc     <= '0;
         drv     <= '0;
         oBusy   <= 1'b0;
         oDone   <= 1'b0;
         oTable  <= '0;
         oMatch  <= 1'b0;
         oErrCnt <= '0;
      end else begin
         oDone <= 1'b0;
         unique case (state)
            IDLE: begin
               drv <= '0;
               if (iStart) begin
                  state   <= HOLD;
                  vec     <= '0;
                  settle  <= '0;
                  acc     <= '0;
                  oBusy   <= 1'b1;
                  oTable  <= '0;
                  oMatch  <= 1'b0;
                  oErrCnt <= '0;
               end
            end
            HOLD: begin
               settle <= settle + 4'd1;
               if (settle == 4'(SETTLE_CYCLES)) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               oTable <= tbl_next;
               acc    <= acc_next;
               if (vec == 4'd15) begin
                  state   <= FINISH;
                  oBusy   <= 1'b0;
                  oDone   <= 1'b1;
                  drv     <= '0;
                  oMatch  <= (tbl_next == EXPECTED);
                  oErrCnt <= acc_next;
                  assert (pop == acc_next);
               end else begin
                  state  <= HOLD;
                  vec    <= vec + 4'd1;
                  settle <= '0;
                  drv    <= vec + 4'd1;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
